// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, element/score/accumulator types and FSM states for the streaming attention PE.
package pe_pkg;
  localparam int DATA_W = 8;
  localparam int SCORE_FRAC = 2 * (DATA_W - 1);
  localparam int W_FRAC = 8;
  localparam int DEF_DIM = 64;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_SCORE_W = 2 * DATA_W + $clog2(DEF_DIM);
  typedef logic signed [DATA_W-1:0] elem_t;
  typedef logic signed [DEF_SCORE_W-1:0] score_t;
  typedef logic signed [DEF_ACC_W-1:0] acc_t;
  typedef elem_t [DEF_DIM-1:0] vec_t;
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, DIVIDE, OUT} state_t;
endpackage

// File: rtl/pe_stream_attn_if.sv
// pe_stream_attn_if: query, key/value stream and output handshakes of one attention PE.
interface pe_stream_attn_if #(
  parameter int DIM = 64,
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int ACC_W = 32
);
  logic q_vld, q_rdy, kv_vld, kv_rdy, kv_last, o_vld, o_rdy;
  logic [DIM*DATA_W-1:0] q_vec, k_vec, v_vec;
  logic [DIM*ACC_W-1:0] o_vec;
  logic [ACC_W-1:0] o_l;
  modport master (output q_vld, q_vec, kv_vld, kv_last, k_vec, v_vec, o_rdy,
                  input q_rdy, kv_rdy, o_vld, o_vec, o_l);
  modport slave (input q_vld, q_vec, kv_vld, kv_last, k_vec, v_vec, o_rdy,
                 output q_rdy, kv_rdy, o_vld, o_vec, o_l);
endinterface

// File: rtl/pe_stream_attn_seq_divider.sv
// seq_divider: restoring signed divider, one quotient bit per cycle, start/done handshake; divisor 0 gives 0.
module seq_divider #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] dividend,
  input  logic        [W-1:0] divisor,
  output logic                done,
  output logic signed [W-1:0] quotient
);
  localparam int CW = $clog2(W + 1);
  logic busy_q, busy_d, neg_q, neg_d, done_q, done_d, ge;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
  logic [W:0] shifted;
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    ge = shifted >= {1'b0, dvs_q};
    busy_d = busy_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    res_d = res_q;
    done_d = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      cnt_d = CW'(W);
      rem_d = '0;
      quo_d = dividend[W-1] ? W'(-dividend) : W'(dividend);
      dvs_d = divisor;
      neg_d = dividend[W-1];
    end else if (busy_q) begin
      rem_d = ge ? W'(shifted - {1'b0, dvs_q}) : shifted[W-1:0];
      quo_d = {quo_q[W-2:0], ge};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        res_d = (dvs_q == '0) ? '0 : neg_q ? -quo_d : quo_d;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy_q <= 1'b0;
      neg_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      res_q <= '0;
    end else begin
      busy_q <= busy_d;
      neg_q <= neg_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      res_q <= res_d;
    end
  assign done = done_q;
  assign quotient = res_q;
endmodule

// File: rtl/pe_stream_attn.sv
// pe_stream_attn: one query against a K/V stream with online base-2 softmax (running max, l, weighted o).
// PE_STREAM_NORMALIZE_EN adds a DIVIDE state emitting o/l in W_FRAC units instead of the raw accumulator.
module pe_stream_attn #(
  parameter int DIM = 64,
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int SCORE_FRAC = pe_pkg::SCORE_FRAC,
  parameter int W_FRAC = pe_pkg::W_FRAC,
  parameter int ACC_W = 32
) (
  input logic clk,
  input logic rst,
  pe_stream_attn_if.slave bus
);
  import pe_pkg::*;
  localparam int SCORE_W = 2 * DATA_W + $clog2(DIM);
  localparam logic [ACC_W-1:0] ONE = ACC_W'(1) << W_FRAC;
  state_t state_q, state_d;
  logic q_rdy_q, q_rdy_d, kv_rdy_q, kv_rdy_d, o_vld_q, o_vld_d;
  logic s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s2_done_q, s2_done_d, first_q, first_d;
  logic signed [DATA_W-1:0] q_q [DIM], q_d [DIM], s1_v_q [DIM], s1_v_d [DIM];
  logic signed [SCORE_W-1:0] score, s1_s_q, s1_s_d, m_q, m_d, m_new;
  logic signed [SCORE_W:0] dif_old, dif_new;
  logic [SCORE_W:0] d_old, d_new;
  logic [ACC_W-1:0] l_q, l_d, o_l_q, o_l_d;
  logic signed [ACC_W-1:0] o_q [DIM], o_d [DIM];
  logic [DIM*ACC_W-1:0] o_vec_q, o_vec_d;
  // Shifts past the accumulator width flush to zero rather than sign-filling.
  function automatic logic signed [ACC_W-1:0] ashr(input logic signed [ACC_W-1:0] x, input logic [SCORE_W:0] d);
    logic signed [ACC_W-1:0] r;
    r = x >>> d;
    return (d >= (SCORE_W+1)'(ACC_W)) ? '0 : r;
  endfunction
`ifdef PE_STREAM_NORMALIZE_EN
  localparam int IW = ($clog2(DIM) > 0) ? $clog2(DIM) : 1;
  logic [IW-1:0] idx_q, idx_d;
  logic div_start_q, div_start_d, div_done;
  logic signed [ACC_W-1:0] div_quo;
  seq_divider #(.W(ACC_W)) u_div (
    .clk(clk), .rst(rst), .start(div_start_q), .dividend(o_q[idx_q] <<< W_FRAC),
    .divisor(l_q), .done(div_done), .quotient(div_quo)
  );
`endif
  always_comb begin
    score = '0;
    for (int i = 0; i < DIM; i++)
      score += SCORE_W'(q_q[i]) * SCORE_W'($signed(bus.k_vec[i*DATA_W +: DATA_W]));
  end
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    m_d = m_q;
    l_d = l_q;
    o_d = o_q;
    first_d = first_q;
    o_vec_d = o_vec_q;
    o_l_d = o_l_q;
`ifdef PE_STREAM_NORMALIZE_EN
    idx_d = idx_q;
    div_start_d = 1'b0;
`endif
    s1_vld_d = bus.kv_vld && kv_rdy_q;
    s1_last_d = s1_vld_d && bus.kv_last;
    s1_s_d = score;
    for (int i = 0; i < DIM; i++) s1_v_d[i] = bus.v_vec[i*DATA_W +: DATA_W];
    s2_done_d = s1_vld_q && s1_last_q;
    m_new = (first_q || s1_s_q > m_q) ? s1_s_q : m_q;
    dif_old = {m_new[SCORE_W-1], m_new} - {m_q[SCORE_W-1], m_q};
    dif_new = {m_new[SCORE_W-1], m_new} - {s1_s_q[SCORE_W-1], s1_s_q};
    d_old = dif_old >>> SCORE_FRAC;
    d_new = dif_new >>> SCORE_FRAC;
    if (s1_vld_q) begin
      m_d = m_new;
      first_d = 1'b0;
      l_d = (first_q ? '0 : ashr(l_q, d_old)) + ashr(ONE, d_new);
      for (int i = 0; i < DIM; i++)
        o_d[i] = (first_q ? '0 : ashr(o_q[i], d_old)) + ashr(ACC_W'(s1_v_q[i]) <<< W_FRAC, d_new);
    end
    case (state_q)
      IDLE: if (bus.q_vld && q_rdy_q) begin
        state_d = ACCUM;
        for (int i = 0; i < DIM; i++) q_d[i] = bus.q_vec[i*DATA_W +: DATA_W];
        m_d = {1'b1, {(SCORE_W-1){1'b0}}};
        l_d = '0;
        for (int i = 0; i < DIM; i++) o_d[i] = '0;
        first_d = 1'b1;
      end
      ACCUM: if (s1_last_d) state_d = DRAIN;
      DRAIN: if (s2_done_q) begin
        o_l_d = l_q;
`ifdef PE_STREAM_NORMALIZE_EN
        state_d = DIVIDE;
        idx_d = '0;
        div_start_d = 1'b1;
`else
        state_d = OUT;
        for (int i = 0; i < DIM; i++) o_vec_d[i*ACC_W +: ACC_W] = o_q[i];
`endif
      end
`ifdef PE_STREAM_NORMALIZE_EN
      DIVIDE: if (div_done) begin
        o_vec_d[idx_q*ACC_W +: ACC_W] = div_quo;
        idx_d = idx_q + IW'(1);
        div_start_d = idx_q != IW'(DIM - 1);
        state_d = (idx_q == IW'(DIM - 1)) ? OUT : DIVIDE;
      end
`endif
      OUT: if (o_vld_q && bus.o_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    q_rdy_d = state_d == IDLE;
    kv_rdy_d = state_d == ACCUM;
    o_vld_d = state_d == OUT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      q_rdy_q <= 1'b0;
      kv_rdy_q <= 1'b0;
      o_vld_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_last_q <= 1'b0;
      s2_done_q <= 1'b0;
      first_q <= 1'b0;
      q_q <= '{default: '0};
      s1_v_q <= '{default: '0};
      o_q <= '{default: '0};
      s1_s_q <= '0;
      m_q <= '0;
      l_q <= '0;
      o_l_q <= '0;
      o_vec_q <= '0;
`ifdef PE_STREAM_NORMALIZE_EN
      idx_q <= '0;
      div_start_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_rdy_q <= q_rdy_d;
      kv_rdy_q <= kv_rdy_d;
      o_vld_q <= o_vld_d;
      s1_vld_q <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s2_done_q <= s2_done_d;
      first_q <= first_d;
      q_q <= q_d;
      s1_v_q <= s1_v_d;
      o_q <= o_d;
      s1_s_q <= s1_s_d;
      m_q <= m_d;
      l_q <= l_d;
      o_l_q <= o_l_d;
      o_vec_q <= o_vec_d;
`ifdef PE_STREAM_NORMALIZE_EN
      idx_q <= idx_d;
      div_start_q <= div_start_d;
`endif
    end
  assign bus.q_rdy = q_rdy_q;
  assign bus.kv_rdy = kv_rdy_q;
  assign bus.o_vld = o_vld_q;
  assign bus.o_vec = o_vec_q;
  assign bus.o_l = o_l_q;
endmodule

// File: tb/tb_pe_stream_attn.sv
// tb_pe_stream_attn: scoreboard bench for pe_stream_attn at DIM=4, ACC_W=32 (either PE_STREAM_NORMALIZE_EN build).
module tb_pe_stream_attn;
  typedef struct packed {
    logic [127:0] o;
    logic [31:0] l;
  } exp_t;
  logic clk, rst;
  int checks, errors;
  exp_t sb[$];
  pe_stream_attn_if #(.DIM(4), .DATA_W(8), .ACC_W(32)) bus ();
  pe_stream_attn #(.DIM(4), .ACC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction
  function automatic exp_t mk(input int a, input int b, input int c, input int d, input int l);
    int v[4];
    exp_t e;
    v = '{a, b, c, d};
`ifdef PE_STREAM_NORMALIZE_EN
    for (int i = 0; i < 4; i++) v[i] = (l == 0) ? 0 : (v[i] * 256) / l;
`endif
    e.o = {v[3], v[2], v[1], v[0]};
    e.l = l;
    return e;
  endfunction
  task automatic send_q(input logic [31:0] q);
    bus.q_vec = q;
    bus.q_vld = 1;
    for (int n = 0; n < 50 && !bus.q_rdy; n++) tick();
    chk("q_hs", bus.q_rdy, 1);
    tick();
    bus.q_vld = 0;
  endtask
  task automatic send_kv(input logic [31:0] k, input logic [31:0] v, input logic last, input logic strict);
    bus.k_vec = k;
    bus.v_vec = v;
    bus.kv_last = last;
    bus.kv_vld = 1;
    if (strict) chk("kv_rdy_stream", bus.kv_rdy, 1);
    for (int n = 0; n < 50 && !bus.kv_rdy; n++) tick();
    chk("kv_hs", bus.kv_rdy, 1);
    tick();
    bus.kv_last = 0;
  endtask
  task automatic chk_lat();
`ifndef PE_STREAM_NORMALIZE_EN
    chk("lat_t1_vld", bus.o_vld, 0);
    chk("lat_t1_kvrdy", bus.kv_rdy, 0);
    tick();
    chk("lat_t2_vld", bus.o_vld, 0);
    tick();
    chk("lat_t3_vld", bus.o_vld, 1);
`endif
  endtask
  task automatic get_o(input string tag);
    exp_t e;
    bus.o_rdy = 1;
    for (int n = 0; n < 1000 && !bus.o_vld; n++) tick();
    chk({tag, "_vld"}, bus.o_vld, 1);
    chk({tag, "_sb"}, 128'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_o"}, bus.o_vec, e.o);
      chk({tag, "_l"}, bus.o_l, e.l);
    end
    tick();
    bus.o_rdy = 0;
  endtask
  initial begin
    clk = 0;
    rst = 1;
    checks = 0;
    errors = 0;
    bus.q_vld = 0; bus.q_vec = 0; bus.kv_vld = 0; bus.kv_last = 0;
    bus.k_vec = 0; bus.v_vec = 0; bus.o_rdy = 0;
    #2 rst = 0;
    #1;
    chk("rst_q_rdy", bus.q_rdy, 0);
    chk("rst_kv_rdy", bus.kv_rdy, 0);
    chk("rst_o_vld", bus.o_vld, 0);
    chk("rst_o_vec", bus.o_vec, 0);
    chk("rst_o_l", bus.o_l, 0);
    tick();
    rst = 1;
    tick();
    chk("idle_q_rdy", bus.q_rdy, 1);
    // single pair with kv_last on the first pair
    send_q(p4(64, 0, 0, 0));
    sb.push_back(mk(2560, 5120, -7680, 10240, 256));
    send_kv(0, p4(10, 20, -30, 40), 1, 1);
    bus.kv_vld = 0;
    chk_lat();
    get_o("single");
    // two equal scores; kv_vld raised in IDLE first must be ignored
    bus.kv_vld = 1;
    bus.v_vec = p4(99, 99, 99, 99);
    tick();
    tick();
    send_q(p4(64, 0, 0, 0));
    sb.push_back(mk(25600, 25600, 0, 0, 512));
    send_kv(0, p4(100, 0, 0, 0), 0, 1);
    send_kv(0, p4(0, 100, 0, 0), 1, 1);
    bus.kv_vld = 0;
    chk_lat();
    get_o("equal2");
    // score jump of integer delta 2
    send_q(p4(127, 127, 127, 0));
    sb.push_back(mk(6400, 0, 0, 0, 320));
    send_kv(0, p4(100, 0, 0, 0), 0, 1);
    send_kv(p4(127, 127, 127, 0), 0, 1, 1);
    bus.kv_vld = 0;
    chk_lat();
    get_o("jump");
    // backpressure: output held, handshakes blocked
    send_q(p4(64, 0, 0, 0));
    sb.push_back(mk(1280, 1536, 1792, 2048, 256));
    send_kv(0, p4(5, 6, 7, 8), 1, 1);
    bus.kv_vld = 0;
    for (int n = 0; n < 1000 && !bus.o_vld; n++) tick();
    bus.q_vld = 1;
    bus.kv_vld = 1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_vld", bus.o_vld, 1);
      chk("bp_o", bus.o_vec, sb[0].o);
      chk("bp_l", bus.o_l, sb[0].l);
      chk("bp_q_rdy", bus.q_rdy, 0);
      chk("bp_kv_rdy", bus.kv_rdy, 0);
      tick();
    end
    bus.q_vld = 0;
    bus.kv_vld = 0;
    get_o("bp");
    chk("bp_rel_q_rdy", bus.q_rdy, 1);
    chk("bp_rel_vld", bus.o_vld, 0);
    // eight back-to-back pairs, kv_vld never dropped
    send_q(p4(64, 0, 0, 0));
    sb.push_back(mk(9216, -9216, 18432, 0, 2048));
    for (int i = 1; i <= 8; i++) send_kv(0, p4(i, -i, 2 * i, 0), i == 8, 1);
    chk_lat();
    get_o("stream");
    bus.kv_vld = 0;
    // reset in the middle of a five-pair sequence
    send_q(p4(127, 127, 127, 0));
    for (int i = 0; i < 3; i++) send_kv(p4(127, 127, 127, 0), p4(50, 50, 50, 50), 0, 1);
    #2 rst = 0;
    #1;
    chk("abort_q_rdy", bus.q_rdy, 0);
    chk("abort_kv_rdy", bus.kv_rdy, 0);
    chk("abort_o_vld", bus.o_vld, 0);
    chk("abort_o_vec", bus.o_vec, 0);
    chk("abort_o_l", bus.o_l, 0);
    bus.kv_vld = 0;
    tick();
    rst = 1;
    tick();
    send_q(p4(64, 0, 0, 0));
    sb.push_back(mk(256, 512, 768, 1024, 256));
    send_kv(0, p4(1, 2, 3, 4), 1, 1);
    bus.kv_vld = 0;
    chk_lat();
    get_o("after_abort");
    chk("sb_drained", 128'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_stream_attn.md
Name: pe_stream_attn

Overview:
- Parametrised successor to the single-vector PE. It takes one query vector, then streams an arbitrary-length sequence of key/value pairs through it, ending with a last flag.
- Performs online-softmax accumulation: running max, base-2 shift-only exponent weighting, and running weighted sum of V with its normaliser l.
- Emits one output vector per query.
- Sits between the Q/K/V SRAM readers and the O SRAM writer. A top level instantiates NUM_PE copies.

Parameters:
- DIM, 64: embedding dimension, number of vector elements.
- DATA_W, 8: element width of q/k/v, signed Q0.7.
- SCORE_FRAC, 14: fractional bits of the dot-product score. Equals 2*(DATA_W-1).
- W_FRAC, 8: fractional bits of the softmax weight; ONE = 1<<W_FRAC.
- ACC_W, 32: signed width of the o accumulator elements and of l.
- SCORE_W, derived: 2*DATA_W + $clog2(DIM), signed.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-low reset.
- q_vld, in, 1: query valid.
- q_rdy, out, 1: query accepted when q_vld&&q_rdy.
- q_vec, in, DIM*DATA_W: query vector.
- kv_vld, in, 1: key/value pair valid.
- kv_rdy, out, 1: pair accepted when kv_vld&&kv_rdy.
- kv_last, in, 1: marks the final pair for the current query.
- k_vec, in, DIM*DATA_W: key vector.
- v_vec, in, DIM*DATA_W: value vector.
- o_vld, out, 1: output valid.
- o_rdy, in, 1: downstream ready.
- o_vec, out, DIM*ACC_W: output vector.
- o_l, out, ACC_W: final normaliser l.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0: q_rdy=0, kv_rdy=0, o_vld=0, o_vec=0, o_l=0.
  - Internal m, l, o, q register and pipeline valid bits are cleared.
- FSM states and transitions:
  - IDLE: q_rdy=1. On a q handshake, latch q, set m=most-negative, l=0, o=0, first=1, then go to ACCUM.
  - ACCUM: kv_rdy=1 only while the stage-1 register is free or advancing. This block never stalls internally, so kv_rdy=1 throughout ACCUM. On accepting a pair with kv_last=1, go to DRAIN; kv_rdy=0 from the next cycle.
  - DRAIN: wait for the stage-2 update of the last pair to complete (one cycle), then go to OUT.
  - OUT: o_vld=1, with o_vec/o_l held stable. On the o handshake, go to IDLE.
- Pipeline:
  - S1 registers the score s = sum(q_i*k_i) at full SCORE_W precision (no saturation), together with v.
  - S2 updates the accumulator state.
- S2 update rules (all shifts arithmetic):
  - m_new = first ? s : max(m, s).
  - d_old = (m_new - m) >>> SCORE_FRAC; d_new = (m_new - s) >>> SCORE_FRAC. Both are integer parts, >=0.
  - A shift >= ACC_W yields 0. When first=1, the old terms are treated as 0.
  - l = (l >> d_old) + (ONE >> d_new).
  - o_i = (o_i >>> d_old) + ((sext(v_i) << W_FRAC) >>> d_new).
  - first is cleared after the update.
- Latency and throughput:
  - A last pair accepted in cycle t gives o_vld high in cycle t+3: S1 at t+1, S2 at t+2, OUT at t+3.
  - One KV pair per cycle sustained.
- Backpressure: o_rdy low holds OUT indefinitely. q_rdy and kv_rdy stay 0 until the output is taken.
- Boundaries:
  - q_vld is ignored outside IDLE; kv_vld is ignored outside ACCUM.
  - A sequence with a single pair (kv_last on the first pair) is legal.
  - No overflow check on l or o. ACC_W must be sized for the maximum sequence length.
  - Reset mid-sequence discards all partial state; there is no output for that query.

Optional Feature:
- Macro: PE_STREAM_NORMALIZE_EN.
- When defined:
  - A DIVIDE state is inserted between DRAIN and OUT.
  - A sequential restoring divider computes o_vec[i] = (o_i << W_FRAC) / l, signed, truncated toward zero, one element at a time, taking ACC_W cycles per element.
  - o_vld is asserted after DIM*ACC_W cycles.
  - If l==0, every element is 0.
- When undefined: o_vec is the raw accumulator o and no divider is built.
- o_l is output in both cases.

Decomposition:
- Shared package pe_pkg:
  - DATA_W, SCORE_FRAC, W_FRAC.
  - typedefs for the element, score, accumulator and vector types.
  - state enum {IDLE, ACCUM, DRAIN, DIVIDE, OUT}.
- One natural sub-module: seq_divider, a restoring signed divider with start/done handshake. It is instantiated only under PE_STREAM_NORMALIZE_EN.

Test Plan (DIM=4, ACC_W=32):
- Single pair: q=[64,0,0,0], k=0, v=[10,20,-30,40], last=1 -> o=[2560,5120,-7680,10240], l=256. With NORMALIZE: o=[2560,5120,-7680,10240]/256 scaled by 256 in W_FRAC units, i.e. [2560,5120,-7680,10240]; o_vld at t+3 without the macro.
- Two equal-score pairs (k=0 for both), v1=[100,0,0,0], v2=[0,100,0,0] -> o=[25600,25600,0,0], l=512.
- Score jump: q=[127,127,127,0]. Pair1 k=0, v=[100,0,0,0]; pair2 k=q (s=48387, integer delta 2), v=0 -> o=[6400,0,0,0], l=320. With NORMALIZE, element0 = 6400*256/320 = 5120 (20.0).
- Backpressure: hold o_rdy=0 for 10 cycles in OUT -> o_vld stays 1, outputs stable, q_rdy=0. Release o_rdy -> IDLE and q_rdy=1 the next cycle.
- Streaming: 8 back-to-back pairs with kv_vld continuously high -> kv_rdy=1 every ACCUM cycle, no pair dropped, l=8*256=2048 for equal scores.
- Reset: assert rst low after 3 of 5 pairs -> all outputs 0 immediately. A new query then produces only its own result, with no residue from the aborted one.
